// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - programmable clock-pattern generator (delay, high, low phases) with tick strobe
// Optional: define CLK_DIV_PERIOD_CNT_EN to add the period_cnt output.
`timescale 1ns/1ps
module clk_div_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_low,
  output logic             clk_out,
  output logic             tick,
`ifdef CLK_DIV_PERIOD_CNT_EN
  output logic [31:0]      period_cnt,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_HIGH, S_LOW} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_q, delay_d, high_q, high_d, low_q, low_d;
  logic [CNT_W-1:0] pdelay_q, pdelay_d, phigh_q, phigh_d, plow_q, plow_d;
  logic             pend_q, pend_d;
  logic             clk_out_q, tick_q, tick_d;
  logic             xfer, commit;
  logic [CNT_W-1:0] new_delay, new_high, new_low;

  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - ONE;
  endfunction

  always_comb begin
    xfer      = cfg_valid && !pend_q;
    // Values that take effect at a commit point: a same-cycle transfer wins, then the shadow.
    new_delay = xfer ? cfg_delay : (pend_q ? pdelay_q : delay_q);
    new_high  = xfer ? cfg_high  : (pend_q ? phigh_q  : high_q);
    new_low   = xfer ? cfg_low   : (pend_q ? plow_q   : low_q);

    state_d  = state_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;
    delay_d  = delay_q;
    high_d   = high_q;
    low_d    = low_q;
    pdelay_d = pdelay_q;
    phigh_d  = phigh_q;
    plow_d   = plow_q;
    pend_d   = pend_q;

    case (state_q)
      S_IDLE: begin
        commit = 1'b1;
        if (en) begin
          if (new_delay != '0) begin
            state_d = S_DELAY;
            cnt_d   = new_delay - ONE;
          end else begin
            state_d = S_HIGH;
            cnt_d   = len_m1(new_high);
          end
        end
      end
      S_DELAY: begin
        if (!en) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          commit  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_HIGH;
          cnt_d   = len_m1(high_q);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_LOW;
          cnt_d   = len_m1(low_q);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_LOW: begin
        if (cnt_q == '0) begin
          commit = 1'b1;
          if (en) begin
            state_d = S_HIGH;
            cnt_d   = len_m1(new_high);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (commit) begin
      delay_d = new_delay;
      high_d  = new_high;
      low_d   = new_low;
      pend_d  = 1'b0;
    end else if (xfer) begin
      pdelay_d = cfg_delay;
      phigh_d  = cfg_high;
      plow_d   = cfg_low;
      pend_d   = 1'b1;
    end

    // HIGH is always entered from a non-HIGH state, so a low clk_out marks the first HIGH cycle.
    tick_d = (state_q == S_HIGH) && !clk_out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      delay_q   <= '0;
      high_q    <= ONE;
      low_q     <= ONE;
      pdelay_q  <= '0;
      phigh_q   <= '0;
      plow_q    <= '0;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      delay_q   <= delay_d;
      high_q    <= high_d;
      low_q     <= low_d;
      pdelay_q  <= pdelay_d;
      phigh_q   <= phigh_d;
      plow_q    <= plow_d;
      pend_q    <= pend_d;
      clk_out_q <= (state_q == S_HIGH);
      tick_q    <= tick_d;
    end
  end

`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [31:0] period_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_q <= '0;
    end else if (state_d == S_IDLE && state_q != S_IDLE) begin
      period_cnt_q <= '0;
    end else if (tick_d) begin
      period_cnt_q <= period_cnt_q + 32'd1;
    end
  end

  assign period_cnt = period_cnt_q;
`endif

  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign busy      = (state_q != S_IDLE);
  assign cfg_ready = !pend_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - directed self-checking bench for clk_div_gen
`timescale 1ns/1ps
module tb_clk_div_gen;

  logic        clk = 1'b0;
  logic        rst, en, cfg_valid, cfg_ready;
  logic [15:0] cfg_delay, cfg_high, cfg_low;
  logic        clk_out, tick, busy;
`ifdef CLK_DIV_PERIOD_CNT_EN
  logic [31:0] period_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] v_clk, v_tick, v_busy, v_rdy;

  clk_div_gen #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_delay  (cfg_delay),
    .cfg_high   (cfg_high),
    .cfg_low    (cfg_low),
    .clk_out    (clk_out),
    .tick       (tick),
`ifdef CLK_DIV_PERIOD_CNT_EN
    .period_cnt (period_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic clear_rec();
    v_clk = '0; v_tick = '0; v_busy = '0; v_rdy = '0;
  endtask

  task automatic rec();
    v_clk  = (v_clk  << 1) | 32'(clk_out);
    v_tick = (v_tick << 1) | 32'(tick);
    v_busy = (v_busy << 1) | 32'(busy);
    v_rdy  = (v_rdy  << 1) | 32'(cfg_ready);
  endtask

  task automatic load_cfg(input logic [15:0] d, input logic [15:0] h, input logic [15:0] l);
    cfg_delay = d; cfg_high = h; cfg_low = l; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    en = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL wait_idle: busy still %b after 200 cycles, required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_delay = '0; cfg_high = '0; cfg_low = '0;
    repeat (2) @(negedge clk);
    n_cmp += 4;
    if (clk_out !== 1'b0) begin n_bad++; $display("FAIL rst_clk_out: got %b required 0", clk_out); end
    if (tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick: got %b required 0", tick); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cfg_ready: got %b required 1", cfg_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_default();
    clear_rec();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); rec(); end
    n_cmp += 3;
    if (v_clk !== 32'h55) begin n_bad++; $display("FAIL default_clk: got %h required %h", v_clk, 32'h55); end
    if (v_tick !== 32'h55) begin n_bad++; $display("FAIL default_tick: got %h required %h", v_tick, 32'h55); end
    if (v_busy !== 32'hFF) begin n_bad++; $display("FAIL default_busy: got %h required %h", v_busy, 32'hFF); end
`ifdef CLK_DIV_PERIOD_CNT_EN
    n_cmp++;
    if (period_cnt !== 32'd4) begin n_bad++; $display("FAIL default_period_cnt: got %0d required 4", period_cnt); end
`endif
    wait_idle();
  endtask

  task automatic test_delay_2_2();
    load_cfg(16'd1, 16'd2, 16'd2);
    n_cmp += 2;
    if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cfg_ready: got %b required 1", cfg_ready); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b required 0", busy); end
    clear_rec();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin @(negedge clk); rec(); end
    n_cmp += 3;
    if (v_clk !== 32'h333) begin n_bad++; $display("FAIL d1h2l2_clk: got %h required %h", v_clk, 32'h333); end
    if (v_tick !== 32'h222) begin n_bad++; $display("FAIL d1h2l2_tick: got %h required %h", v_tick, 32'h222); end
    if (v_busy !== 32'hFFF) begin n_bad++; $display("FAIL d1h2l2_busy: got %h required %h", v_busy, 32'hFFF); end
    wait_idle();
  endtask

  task automatic test_6_5_and_zero();
    load_cfg(16'd0, 16'd6, 16'd5);
    clear_rec();
    en = 1'b1;
    for (int i = 0; i < 24; i++) begin @(negedge clk); rec(); end
    n_cmp += 2;
    if (v_clk !== 32'h7E0FC1) begin n_bad++; $display("FAIL h6l5_clk: got %h required %h", v_clk, 32'h7E0FC1); end
    if (v_tick !== 32'h400801) begin n_bad++; $display("FAIL h6l5_tick: got %h required %h", v_tick, 32'h400801); end
    wait_idle();
    load_cfg(16'd0, 16'd0, 16'd0);
    clear_rec();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin @(negedge clk); rec(); end
    n_cmp += 2;
    if (v_clk !== 32'h55) begin n_bad++; $display("FAIL h0l0_clk: got %h required %h", v_clk, 32'h55); end
    if (v_tick !== 32'h55) begin n_bad++; $display("FAIL h0l0_tick: got %h required %h", v_tick, 32'h55); end
    wait_idle();
  endtask

  task automatic test_midcfg();
    // Config offered together with en in IDLE, then a 3/1 update mid-HIGH.
    cfg_delay = 16'd0; cfg_high = 16'd2; cfg_low = 16'd2; cfg_valid = 1'b1; en = 1'b1;
    clear_rec();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rec();
      if (i == 0) cfg_valid = 1'b0;
      if (i == 1) begin cfg_high = 16'd3; cfg_low = 16'd1; cfg_valid = 1'b1; end
      if (i == 2) cfg_valid = 1'b0;
    end
    n_cmp += 2;
    if (v_clk !== 32'h6777) begin n_bad++; $display("FAIL midcfg_clk: got %h required %h", v_clk, 32'h6777); end
    if (v_rdy !== 32'hCFFF) begin n_bad++; $display("FAIL midcfg_ready: got %h required %h", v_rdy, 32'hCFFF); end
    wait_idle();
  endtask

  task automatic test_stop();
    load_cfg(16'd0, 16'd4, 16'd4);
    clear_rec();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rec();
      if (i == 1) en = 1'b0;
    end
    n_cmp += 3;
    if (v_clk !== 32'h780) begin n_bad++; $display("FAIL stop44_clk: got %h required %h", v_clk, 32'h780); end
    if (v_tick !== 32'h400) begin n_bad++; $display("FAIL stop44_tick: got %h required %h", v_tick, 32'h400); end
    if (v_busy !== 32'hFF0) begin n_bad++; $display("FAIL stop44_busy: got %h required %h", v_busy, 32'hFF0); end

    load_cfg(16'd10, 16'd1, 16'd1);
    clear_rec();
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rec();
      if (i == 2) en = 1'b0;
    end
    n_cmp += 2;
    if (v_clk !== 32'h0) begin n_bad++; $display("FAIL stopdly_clk: got %h required %h", v_clk, 32'h0); end
    if (v_busy !== 32'hE000) begin n_bad++; $display("FAIL stopdly_busy: got %h required %h", v_busy, 32'hE000); end
  endtask

  task automatic test_reset_mid();
    load_cfg(16'd0, 16'd2, 16'd2);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) begin cfg_high = 16'd5; cfg_low = 16'd5; cfg_valid = 1'b1; end
      if (i == 2) cfg_valid = 1'b0;
    end
    n_cmp += 2;
    if (clk_out !== 1'b1) begin n_bad++; $display("FAIL pre_rst_clk: got %b required 1", clk_out); end
    if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL pre_rst_ready: got %b required 0", cfg_ready); end
    #2 rst = 1'b1;
    #1;
    n_cmp += 4;
    if (clk_out !== 1'b0) begin n_bad++; $display("FAIL async_rst_clk: got %b required 0", clk_out); end
    if (tick !== 1'b0) begin n_bad++; $display("FAIL async_rst_tick: got %b required 0", tick); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL async_rst_busy: got %b required 0", busy); end
    if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_ready: got %b required 1", cfg_ready); end
`ifdef CLK_DIV_PERIOD_CNT_EN
    n_cmp++;
    if (period_cnt !== 32'd0) begin n_bad++; $display("FAIL async_rst_pcnt: got %0d required 0", period_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    clear_rec();
    for (int i = 0; i < 8; i++) begin @(negedge clk); rec(); end
    n_cmp += 2;
    if (v_clk !== 32'h55) begin n_bad++; $display("FAIL post_rst_clk: got %h required %h", v_clk, 32'h55); end
    if (v_tick !== 32'h55) begin n_bad++; $display("FAIL post_rst_tick: got %h required %h", v_tick, 32'h55); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_default();
    test_delay_2_2();
    test_6_5_and_zero();
    test_midcfg();
    test_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Synthesizable programmable clock-pattern generator driven from the single system clock.
- Produces a divided square wave `clk_out` with a programmable start delay and independent high and low phase lengths, counted in `clk` cycles.
- Replaces the behavioural `#`-delay clock sources with a real RTL block feeding downstream sampled logic.
- Also emits a one-cycle `tick` strobe at each rising edge of `clk_out`, for use as a clock enable.

Parameters:
- CNT_W, 16, width of the delay/high/low counters and config fields.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run request; level-sensitive.
- cfg_valid  input  1  new configuration offered.
- cfg_ready  output  1  block can accept a configuration this cycle.
- cfg_delay  input  CNT_W  cycles of low output between start and first rising edge.
- cfg_high  input  CNT_W  high-phase length in cycles; 0 treated as 1.
- cfg_low  input  CNT_W  low-phase length in cycles; 0 treated as 1.
- clk_out  output  1  generated divided clock, registered.
- tick  output  1  one-cycle pulse on the first high cycle of each clk_out period.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, clk_out=0, tick=0, busy=0, cfg_ready=1, counters=0.
  - Active config = delay 0, high 1, low 1. No pending config.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - In IDLE the values load into the active registers immediately.
  - Otherwise they load into a pending shadow and cfg_ready drops to 0.
  - The pending shadow is applied on the LOW->HIGH period boundary (or on entry to IDLE), then cfg_ready returns to 1 the next cycle.
  - A config accepted in IDLE in the same cycle en is sampled high is the one used.
- States:
  - IDLE:
    - clk_out=0.
    - On en=1: go to DELAY if delay>0, else HIGH.
  - DELAY:
    - clk_out=0; lasts exactly `delay` cycles, then HIGH.
    - en=0 during DELAY returns to IDLE next cycle.
  - HIGH:
    - clk_out=1 for exactly max(high,1) cycles, then LOW.
    - tick=1 only on the first HIGH cycle.
  - LOW:
    - clk_out=0 for exactly max(low,1) cycles.
    - On the last LOW cycle: HIGH if en=1, else IDLE.
- Output timing:
  - clk_out is registered.
  - With en sampled high at edge k in IDLE, the first high cycle of clk_out begins after edge k+1+delay.
  - Period is max(high,1)+max(low,1) cycles.
- Stop behaviour:
  - en=0 never truncates a HIGH or LOW phase. The current period completes, so there are no runt pulses.
  - en re-asserted before the period ends continues seamlessly.
- Counters:
  - Count down from the loaded value minus 1.
  - No wrap; the all-ones value of CNT_W is a legal maximum.
- Simultaneous events: a config transfer and the period boundary in the same cycle apply the new config at that boundary, and cfg_ready stays 1.
- Reset mid-operation: immediately forces clk_out=0 and state IDLE, and discards any pending config.

Optional Feature:
- Macro: CLK_DIV_PERIOD_CNT_EN.
- When defined:
  - Adds output `period_cnt` [31:0], incremented by 1 at every tick and wrapping at 2^32-1 -> 0.
  - Reset value 0; cleared on entry to IDLE.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then en=1 with defaults (delay 0, high 1, low 1) -> clk_out toggles every cycle (half clk rate), tick every 2nd cycle, first high 1 cycle after en sampled.
- Config delay=1, high=2, low=2 in IDLE, then en=1 -> clk_out low 1 extra cycle, then 2 high / 2 low repeating, tick period 4, busy=1 throughout.
- Config high=6, low=5 (11-cycle period, ~9.09 MHz from 100 MHz) -> measured period 11 cycles, duty 6/11; high=0, low=0 -> behaves as 1/1.
- While running at 2/2, offer high=3, low=1 mid-HIGH -> cfg_ready falls; the current period stays 2/2; the next period is 3/1; cfg_ready returns to 1 one cycle after the boundary.
- Drop en in the first HIGH cycle of a 4/4 pattern -> clk_out completes 4 high + 4 low, then IDLE, busy=0; drop en during delay=10 -> IDLE next cycle, clk_out never rises.
- Assert rst mid-HIGH with a pending config -> clk_out=0 and tick=0 asynchronously; after release, en=1 runs the default 1/1 pattern and the pending config is not applied (with CLK_DIV_PERIOD_CNT_EN: period_cnt=0).
